priority_encoder_iter: RTL and testbench
========================================

PRIORITY_ENCODER_ITER -- requirements
Module: priority_encoder_iter

Interface
REQ-001 Parameter WIDTH, default 16, input word width (>=2).
REQ-002 Parameter DIR, default SCAN_LSB, scan order (SCAN_LSB = right-to-left, SCAN_MSB = left-to-right).
REQ-003 Localparam IDX_W = $clog2(WIDTH).
REQ-004 clk_i  input  1  single clock, all logic on rising edge.
REQ-005 srst_i  input  1  reset, synchronous, active-high.
REQ-006 data_i  input  WIDTH  word to decompose.
REQ-007 data_val_i  input  1  data_i valid.
REQ-008 data_ready_o  output  1  block can accept a word.
REQ-009 data_o  output  WIDTH  one-hot of current set bit, or 0 for a zero word.
REQ-010 idx_o  output  IDX_W  binary index of the data_o bit.
REQ-011 zero_o  output  1  current beat reports an all-zero input word.
REQ-012 last_o  output  1  final beat of current word.
REQ-013 data_val_o  output  1  output beat valid.
REQ-014 ready_i  input  1  downstream accepts beat.

Function
REQ-015 Accept occurs on a cycle with data_val_i && data_ready_o; the word is captured into an internal residue register.
REQ-016 States: IDLE (no residue) and SCAN (residue pending); IDLE->SCAN on accept; SCAN->IDLE on handshake of the last_o beat with no simultaneous accept.
REQ-017 First beat of an accepted word is presented (data_val_o=1) on the cycle after accept; latency 1.
REQ-018 Each beat carries the lowest set residue bit (SCAN_LSB) or the highest (SCAN_MSB) in data_o, its index in idx_o.
REQ-019 On beat handshake (data_val_o && ready_i) that bit is cleared from the residue; the next beat appears the following cycle, one beat per cycle at full throughput.
REQ-020 last_o = 1 when the residue holds exactly one set bit (or the word was zero).
REQ-021 Zero word: exactly one beat, data_o=0, idx_o=0, zero_o=1, last_o=1.
REQ-022 While data_val_o && !ready_i, data_o, idx_o, zero_o, last_o and data_val_o hold stable.
REQ-023 data_ready_o = !data_val_o || (last_o && ready_i); combinational from ready_i, allowing back-to-back words without a bubble.
REQ-024 Simultaneous last-beat handshake and new accept: new word's first beat presented next cycle, state stays SCAN.
REQ-025 data_i ignored when data_val_i=0 or data_ready_o=0.
REQ-026 When data_val_o=0, data_o, idx_o, zero_o, last_o are 0.

Reset
REQ-027 srst_i sampled high: next cycle data_val_o=0, data_o=0, idx_o=0, zero_o=0, last_o=0, residue=0, state IDLE, data_ready_o=1.
REQ-028 Reset mid-scan discards remaining beats of the word; no beat of it is emitted after reset.
REQ-029 Accept on a cycle with srst_i high is discarded.

Structure
REQ-030 Package priority_encoder_pkg holds typedef enum scan_dir_t {SCAN_LSB, SCAN_MSB} and state typedef state_t {IDLE, SCAN}.
REQ-031 One combinational sub-module priority_bit_pick (params WIDTH, DIR): input word -> one-hot, index, any_set; instanced once on the residue.
REQ-032 All outputs driven from registers except data_ready_o.

Verification
REQ-033 WIDTH=16, SCAN_LSB, data_i=16'h8421, ready_i=1 -> 4 consecutive beats 0001/idx0, 0020/idx5, 0400/idx10, 8000/idx15, last_o only on 4th.
REQ-034 SCAN_MSB, data_i=16'h8421 -> beats 8000/15, 0400/10, 0020/5, 0001/0 (last).
REQ-035 data_i=16'h0000 -> single beat data_o=0, zero_o=1, last_o=1; data_ready_o high again same cycle as handshake.
REQ-036 data_i=16'h0003, ready_i low 3 cycles -> beat 0001/idx0 held stable 4 cycles, data_ready_o=0; then 0002/idx1 last.
REQ-037 data_i=16'hFFFF, srst_i after 2 handshaken beats -> next cycle data_val_o=0, data_ready_o=1, no further beats of that word.
REQ-038 data_i=16'h0001 then 16'h0002 on consecutive accepts, ready_i=1 -> beats 0001/last and 0002/last on consecutive cycles, no bubble.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// -----------------------------------------------------------------------------
// priority_encoder_pkg
// Shared types for the iterative priority encoder:
//   scan_dir_t : which end of the word is reported first
//   state_t    : controller state (IDLE = no residue, SCAN = residue pending)
// -----------------------------------------------------------------------------
package priority_encoder_pkg;

  typedef enum logic {
    SCAN_LSB = 1'b0,  // right-to-left: lowest set bit first
    SCAN_MSB = 1'b1   // left-to-right: highest set bit first
  } scan_dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/priority_bit_pick.sv
// -----------------------------------------------------------------------------
// priority_bit_pick
// Combinational pick of the first set bit of a word in the given scan order.
//   i_word   in  WIDTH  word to inspect
//   o_onehot out WIDTH  one-hot of the picked bit (0 when the word is zero)
//   o_idx    out IDX_W  binary index of the picked bit (0 when the word is zero)
//   o_any    out 1      word has at least one set bit
// -----------------------------------------------------------------------------
module priority_bit_pick
  import priority_encoder_pkg::*;
#(
  parameter int        WIDTH = 16,
  parameter scan_dir_t DIR   = SCAN_LSB,
  localparam int       IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_word,
  output logic [WIDTH-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // The loop walks from the low-priority end toward the high-priority end,
  // so the last set bit visited overwrites earlier ones and wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = |i_word;
    if (DIR == SCAN_LSB) begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (i_word[i]) begin
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_idx       = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_word[i]) begin
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_idx       = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder_iter.sv
// -----------------------------------------------------------------------------
// priority_encoder_iter
// Decomposes each accepted word into one beat per set bit (or a single zero
// beat for an all-zero word), in LSB-first or MSB-first order.
//   clk_i        in   1      clock, rising edge
//   srst_i       in   1      synchronous active-high reset
//   data_i       in   WIDTH  word to decompose
//   data_val_i   in   1      data_i valid
//   data_ready_o out  1      block can accept a word (combinational on ready_i)
//   data_o       out  WIDTH  one-hot of current bit, 0 for a zero word
//   idx_o        out  IDX_W  index of the data_o bit
//   zero_o       out  1      beat reports an all-zero word
//   last_o       out  1      final beat of the word
//   data_val_o   out  1      beat valid
//   ready_i      in   1      downstream accepts the beat
// -----------------------------------------------------------------------------
module priority_encoder_iter
  import priority_encoder_pkg::*;
#(
  parameter int        WIDTH = 16,
  parameter scan_dir_t DIR   = SCAN_LSB,
  localparam int       IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o,
  output logic             last_o,
  output logic             data_val_o,
  input  logic             ready_i
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_resid;    // bits still to report, including the current beat
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_idx;
  logic             r_zero;
  logic             r_last;

  logic             w_acc;
  logic             w_hs;
  logic             w_load;     // present a new beat next cycle
  logic             w_clear;    // word finished, go quiet next cycle
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_pick_in;
  logic [WIDTH-1:0] w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_pick_last;

  assign data_val_o   = (r_state == SCAN);
  assign data_o       = r_data;
  assign idx_o        = r_idx;
  assign zero_o       = r_zero;
  assign last_o       = r_last;

  // Ready looks through to ready_i so a new word can follow the last beat
  // of the previous one without a bubble.
  assign data_ready_o = !data_val_o || (r_last && ready_i);

  assign w_acc = data_val_i && data_ready_o;
  assign w_hs  = data_val_o && ready_i;

  // The picker runs on the residue's next value rather than its current one,
  // so the beat fields can be registered alongside the residue itself.
  assign w_left    = r_resid & ~r_data;
  assign w_pick_in = w_acc ? data_i : w_left;

  priority_bit_pick #(
    .WIDTH (WIDTH),
    .DIR   (DIR)
  ) u_pick (
    .i_word   (w_pick_in),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Nothing left after removing the picked bit: that beat closes the word.
  // A zero word lands here too, giving its single beat last_o=1.
  assign w_pick_last = ~|(w_pick_in & ~w_onehot);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_state_nxt = SCAN;
          w_load      = 1'b1;
        end
      end
      SCAN: begin
        if (w_acc) begin
          // Accept is only possible alongside the last-beat handshake.
          w_load = 1'b1;
        end else if (w_hs && !r_last) begin
          w_load = 1'b1;
        end else if (w_hs) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clear     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_resid <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_zero  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_resid <= w_pick_in;
        r_data  <= w_onehot;
        r_idx   <= w_idx;
        r_zero  <= !w_any;
        r_last  <= w_pick_last;
      end else if (w_clear) begin
        r_resid <= '0;
        r_data  <= '0;
        r_idx   <= '0;
        r_zero  <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_iter.sv
module tb_priority_encoder_iter;
  import priority_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        srst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        data_val_i = 1'b0;
  logic        ready_i = 1'b1;

  logic        a_rdy, a_val, a_z, a_l, b_rdy, b_val, b_z, b_l;
  logic [15:0] a_d, b_d;
  logic [3:0]  a_ix, b_ix;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  priority_encoder_iter #(.WIDTH(16), .DIR(SCAN_LSB)) dut_a (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .data_ready_o(a_rdy), .data_o(a_d), .idx_o(a_ix), .zero_o(a_z),
    .last_o(a_l), .data_val_o(a_val), .ready_i(ready_i));

  priority_encoder_iter #(.WIDTH(16), .DIR(SCAN_MSB)) dut_b (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .data_ready_o(b_rdy), .data_o(b_d), .idx_o(b_ix), .zero_o(b_z),
    .last_o(b_l), .data_val_o(b_val), .ready_i(ready_i));

  // ---------------- reference model: queue of pending beats per direction
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  ix;
    logic        z;
    logic        l;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  task automatic push_word(input logic [15:0] w);
    int n, c;
    n = $countones(w);
    if (w == 16'h0) begin
      qa.push_back('{d: 16'h0, ix: 4'h0, z: 1'b1, l: 1'b1});
      qb.push_back('{d: 16'h0, ix: 4'h0, z: 1'b1, l: 1'b1});
    end else begin
      c = 0;
      for (int i = 0; i < 16; i++)
        if (w[i]) begin
          c++;
          qa.push_back('{d: 16'h1 << i, ix: 4'(i), z: 1'b0, l: (c == n)});
        end
      c = 0;
      for (int i = 15; i >= 0; i--)
        if (w[i]) begin
          c++;
          qb.push_back('{d: 16'h1 << i, ix: 4'(i), z: 1'b0, l: (c == n)});
        end
    end
  endtask

  function automatic bit model_ready();
    return (qa.size() == 0) || (qa[0].l && ready_i);
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (srst_i) begin
      qa.delete();
      qb.delete();
    end else begin
      acc = data_val_i && model_ready();
      if (qa.size() > 0 && ready_i) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc) push_word(data_i);
    end
  end

  // ---------------- checking
  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got rdy/val/data/idx/zero/last=%h required %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [23:0] pa();
    return {a_rdy, a_val, a_d, a_ix, a_z, a_l};
  endfunction
  function automatic logic [23:0] pb();
    return {b_rdy, b_val, b_d, b_ix, b_z, b_l};
  endfunction
  function automatic logic [23:0] L(input logic r, input logic v, input logic [15:0] d,
                                    input logic [3:0] ix, input logic z, input logic l);
    return {r, v, d, ix, z, l};
  endfunction

  always @(negedge clk) begin
    logic r;
    if (chk_en) begin
      r = model_ready();
      if (qa.size() > 0) check("model_lsb", pa(), {r, 1'b1, qa[0]});
      else               check("model_lsb", pa(), {r, 23'h0});
      if (qb.size() > 0) check("model_msb", pb(), {r, 1'b1, qb[0]});
      else               check("model_msb", pb(), {r, 23'h0});
    end
  end

  // ---------------- stimulus
  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic s);
    data_val_i = v; data_i = d; ready_i = r; srst_i = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] lsbd [4];
    logic [3:0]  lsbi [4];
    int          mode;
    logic [15:0] w;
    lsbd = '{16'h0001, 16'h0020, 16'h0400, 16'h8000};
    lsbi = '{4'd0, 4'd5, 4'd10, 4'd15};

    drive(0, 16'h0, 1, 1);
    tick(); tick();
    drive(0, 16'h0, 1, 0);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_lsb", pa(), L(1, 0, 16'h0, 4'h0, 0, 0));
    check("reset_msb", pb(), L(1, 0, 16'h0, 4'h0, 0, 0));
    tick();

    // 16'h8421, both scan orders, full throughput
    drive(1, 16'h8421, 1, 0);
    tick();
    drive(0, 16'hDEAD, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("w8421_lsb", pa(), L(k == 3, 1, lsbd[k], lsbi[k], 0, k == 3));
      check("w8421_msb", pb(), L(k == 3, 1, lsbd[3-k], lsbi[3-k], 0, k == 3));
      tick();
    end
    @(negedge clk);
    check("w8421_done", pa(), L(1, 0, 16'h0, 4'h0, 0, 0));
    tick();

    // zero word
    drive(1, 16'h0000, 1, 0);
    tick();
    drive(0, 16'h0, 1, 0);
    @(negedge clk);
    check("zero_lsb", pa(), L(1, 1, 16'h0, 4'h0, 1, 1));
    check("zero_msb", pb(), L(1, 1, 16'h0, 4'h0, 1, 1));
    tick();
    @(negedge clk);
    check("zero_done", pa(), L(1, 0, 16'h0, 4'h0, 0, 0));
    tick();

    // 16'h0003 with back-pressure for 3 cycles
    drive(1, 16'h0003, 0, 0);
    tick();
    drive(0, 16'h0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ready_i = 1'b1;
      @(negedge clk);
      check("hold_lsb", pa(), L(0, 1, 16'h0001, 4'd0, 0, 0));
      check("hold_msb", pb(), L(0, 1, 16'h0002, 4'd1, 0, 0));
      tick();
    end
    @(negedge clk);
    check("hold2_lsb", pa(), L(1, 1, 16'h0002, 4'd1, 0, 1));
    check("hold2_msb", pb(), L(1, 1, 16'h0001, 4'd0, 0, 1));
    tick();

    // 16'hFFFF, reset after two handshaken beats
    drive(1, 16'hFFFF, 1, 0);
    tick();
    drive(0, 16'h0, 1, 0);
    @(negedge clk);
    check("ffff_b0", pa(), L(0, 1, 16'h0001, 4'd0, 0, 0));
    tick();
    @(negedge clk);
    check("ffff_b1", pa(), L(0, 1, 16'h0002, 4'd1, 0, 0));
    tick();
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    @(negedge clk);
    check("ffff_rst_lsb", pa(), L(1, 0, 16'h0, 4'h0, 0, 0));
    check("ffff_rst_msb", pb(), L(1, 0, 16'h0, 4'h0, 0, 0));
    tick();
    @(negedge clk);
    check("ffff_quiet", pa(), L(1, 0, 16'h0, 4'h0, 0, 0));
    tick();

    // accept while in reset is dropped
    drive(1, 16'hFFFF, 1, 1);
    tick();
    drive(0, 16'h0, 1, 0);
    @(negedge clk);
    check("acc_in_rst", pa(), L(1, 0, 16'h0, 4'h0, 0, 0));
    tick();

    // back-to-back single-bit words
    drive(1, 16'h0001, 1, 0);
    tick();
    drive(1, 16'h0002, 1, 0);
    @(negedge clk);
    check("b2b_0", pa(), L(1, 1, 16'h0001, 4'd0, 0, 1));
    tick();
    drive(0, 16'h0, 1, 0);
    @(negedge clk);
    check("b2b_1", pa(), L(1, 1, 16'h0002, 4'd1, 0, 1));
    check("b2b_1m", pb(), L(1, 1, 16'h0002, 4'd1, 0, 1));
    tick();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: w = 16'h0;
        1: w = 16'h1 << $urandom_range(0, 15);
        2: w = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: w = 16'($urandom);
      endcase
      drive(($urandom_range(0, 2) != 0), w, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) == 0));
      tick();
    end
    drive(0, 16'h0, 1, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
